// File: rtl/pll_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_test_pkg
// Description : Shared definitions for the PLL test sequencer. Holds the
//               pllTest slave register map, the result slot indices and the
//               sequencer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_test_pkg;

  // pllTest slave register map
  localparam logic [3:0] ADDR_GO      = 4'h0;
  localparam logic [3:0] ADDR_COUNT   = 4'h1;
  localparam logic [3:0] ADDR_CLEAR   = 4'h2;
  localparam logic [3:0] ADDR_REF     = 4'h3;
  localparam logic [3:0] ADDR_CNT0    = 4'h4;
  localparam logic [3:0] ADDR_CNT1    = 4'h5;
  localparam logic [3:0] ADDR_CNT2    = 4'h6;
  localparam logic [3:0] ADDR_CNT3    = 4'h7;
  localparam logic [3:0] ADDR_CNT4    = 4'h8;
  localparam logic [3:0] ADDR_CNT5    = 4'h9;
  localparam logic [3:0] ADDR_LOCKED  = 4'hA;
  localparam logic [3:0] ADDR_PLLRST  = 4'hB;
  localparam logic [3:0] ADDR_ID      = 4'hC;

  // Result slots, filled in readback order
  localparam int         NUM_RESULTS  = 9;
  localparam logic [3:0] RES_REF      = 4'd0;
  localparam logic [3:0] RES_LOCKED   = 4'd7;
  localparam logic [3:0] RES_ID       = 4'd8;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    PR_ASSERT   = 4'd1,
    PR_DEASSERT = 4'd2,
    LOCK_POLL   = 4'd3,
    LOCK_WAIT   = 4'd4,
    WR_CLEAR    = 4'd5,
    WR_COUNT    = 4'd6,
    WR_GO       = 4'd7,
    GO_POLL     = 4'd8,
    RD_WAIT     = 4'd9,
    SETTLE      = 4'd10,
    READBACK    = 4'd11,
    RB_WAIT     = 4'd12,
    WR_STOP     = 4'd13,
    FINISH      = 4'd14
  } state_t;

  // Slots 0..7 map onto contiguous registers 3..A; the ID slot skips PLLRST.
  function automatic logic [3:0] readback_addr(input logic [3:0] idx);
    return (idx == RES_ID) ? ADDR_ID : (idx + ADDR_REF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_test_sequencer_avalon_master_port.sv
`default_nettype none
// ============================================================================
// Module      : avalon_master_port
// Description : Single-cycle Avalon-MM strobe generator. A request is only
//               taken while no strobe is on the bus, so consecutive requests
//               are always separated by at least one idle cycle. Read data
//               (fixed latency 1) is flagged with rd_valid one cycle after
//               the read strobe.
// Ports       : clk, rst          - clock, async active-high reset
//               wr_req, rd_req    - one-cycle request pulses (only when ready)
//               req_addr/wdata    - request address and write data
//               ready             - bus idle, a request may be issued
//               rd_valid/rd_data  - returned read data
//               address, write, read, writedata, readdata - Avalon-MM bus
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_master_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [3:0]  address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  logic rd_pending;

  assign ready    = !write && !read;
  assign rd_valid = rd_pending;
  assign rd_data  = readdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address    <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
      writedata  <= '0;
      rd_pending <= 1'b0;
    end else begin
      // Write wins if both are ever raised, so the strobes stay exclusive.
      write      <= wr_req && ready;
      read       <= rd_req && !wr_req && ready;
      rd_pending <= read;
      if ((wr_req || rd_req) && ready) begin
        address   <= req_addr;
        writedata <= wr_req ? req_wdata : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_test_sequencer
// Description : Avalon-MM master that runs one PLL measurement on the pllTest
//               slave: optional PLL reset + lock wait, clear, load count, go,
//               poll go, settle, then read back all counters into 9 result
//               slots exposed through an indexed read port.
// Ports       : avalon_clock, reset      - clock, async active-high reset
//               start, count_num         - run request and reference count
//               address .. readdata      - Avalon-MM master bus
//               busy, done               - run status, done is a 1-cycle pulse
//               timeout_error, id_error  - sticky until the next start
//               result_sel, result_data  - result read port (0 beyond slot 8)
// Revision    : 1.0 - initial release
// ============================================================================
module pll_test_sequencer
  import pll_test_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = 32'd1,
  parameter int unsigned POLL_LIMIT    = 65535,
  parameter int unsigned SETTLE_CYCLES = 16,   // must be >= 1
  parameter bit          DO_PLL_RESET  = 1'b0
) (
  input  logic        avalon_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] count_num,
  output logic [3:0]  address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        timeout_error,
  output logic        id_error,
  input  logic [3:0]  result_sel,
  output logic [31:0] result_data
);

  localparam logic [31:0] POLL_LAST   = 32'(POLL_LIMIT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t      state, next_state;
  logic [31:0] count_q;
  logic [31:0] cnt;          // poll counter, reused as settle counter
  logic [3:0]  rb_idx;
  logic [31:0] result [NUM_RESULTS];

  logic        wr_req, rd_req, ready, rd_valid;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata, rd_data;
  logic        accept, cnt_clr, cnt_inc, rb_inc, cap_en, set_timeout, set_id_err;

  avalon_master_port u_port (
    .clk       (avalon_clock),
    .rst       (reset),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ready     (ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .address   (address),
    .write     (write),
    .read      (read),
    .writedata (writedata),
    .readdata  (readdata)
  );

  always_ff @(posedge avalon_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    req_addr    = ADDR_GO;
    req_wdata   = '0;
    accept      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    rb_inc      = 1'b0;
    cap_en      = 1'b0;
    set_timeout = 1'b0;
    set_id_err  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        next_state = DO_PLL_RESET ? PR_ASSERT : WR_CLEAR;
      end
      PR_ASSERT: if (ready) begin
        wr_req = 1'b1; req_addr = ADDR_PLLRST; req_wdata = 32'd1;
        next_state = PR_DEASSERT;
      end
      PR_DEASSERT: if (ready) begin
        wr_req = 1'b1; req_addr = ADDR_PLLRST;
        cnt_clr = 1'b1;
        next_state = LOCK_POLL;
      end
      LOCK_POLL: if (ready) begin
        rd_req = 1'b1; req_addr = ADDR_LOCKED;
        next_state = LOCK_WAIT;
      end
      LOCK_WAIT: if (rd_valid) begin
        if (rd_data[0]) begin
          next_state = WR_CLEAR;
        end else if (cnt == POLL_LAST) begin
          set_timeout = 1'b1;
          next_state  = WR_STOP;
        end else begin
          cnt_inc    = 1'b1;
          next_state = LOCK_POLL;
        end
      end
      WR_CLEAR: if (ready) begin
        wr_req = 1'b1; req_addr = ADDR_CLEAR;
        next_state = WR_COUNT;
      end
      WR_COUNT: if (ready) begin
        wr_req = 1'b1; req_addr = ADDR_COUNT; req_wdata = count_q;
        next_state = WR_GO;
      end
      WR_GO: if (ready) begin
        wr_req = 1'b1; req_addr = ADDR_GO; req_wdata = 32'd1;
        cnt_clr = 1'b1;
        next_state = GO_POLL;
      end
      GO_POLL: if (ready) begin
        rd_req = 1'b1; req_addr = ADDR_GO;
        next_state = RD_WAIT;
      end
      RD_WAIT: if (rd_valid) begin
        if (!rd_data[0]) begin
          cnt_clr    = 1'b1;
          next_state = SETTLE;
        end else if (cnt == POLL_LAST) begin
          set_timeout = 1'b1;
          next_state  = WR_STOP;
        end else begin
          cnt_inc    = 1'b1;
          next_state = GO_POLL;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) next_state = READBACK;
        else                    cnt_inc    = 1'b1;
      end
      READBACK: if (ready) begin
        rd_req = 1'b1; req_addr = readback_addr(rb_idx);
        next_state = RB_WAIT;
      end
      RB_WAIT: if (rd_valid) begin
        cap_en = 1'b1;
        if (rb_idx == RES_ID) begin
          set_id_err = (rd_data != EXPECTED_ID);
          next_state = FINISH;
        end else begin
          rb_inc     = 1'b1;
          next_state = READBACK;
        end
      end
      WR_STOP: if (ready) begin
        wr_req = 1'b1; req_addr = ADDR_GO;
        next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge avalon_clock or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      cnt           <= '0;
      rb_idx        <= '0;
      timeout_error <= 1'b0;
      id_error      <= 1'b0;
      for (int i = 0; i < NUM_RESULTS; i++) result[i] <= '0;
    end else begin
      if (accept) begin
        count_q       <= count_num;
        rb_idx        <= '0;
        timeout_error <= 1'b0;
        id_error      <= 1'b0;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 32'd1;
      if (rb_inc)      rb_idx        <= rb_idx + 4'd1;
      if (set_timeout) timeout_error <= 1'b1;
      if (set_id_err)  id_error      <= 1'b1;
      if (cap_en) begin
        for (int i = 0; i < NUM_RESULTS; i++)
          if (rb_idx == 4'(i)) result[i] <= rd_data;
      end
    end
  end

  assign busy = (state != IDLE) && (state != FINISH);
  assign done = (state == FINISH);

  always_comb begin
    result_data = '0;
    for (int i = 0; i < NUM_RESULTS; i++)
      if (result_sel == 4'(i)) result_data = result[i];
  end

endmodule
`default_nettype wire

// File: doc/pll_test_sequencer.md
Name: pll_test_sequencer

Overview:
- Avalon-MM master that runs one complete PLL measurement on the pllTest counter slave: clear, load count, start, poll until finished, then read back every counter.
- Lives in the same Qsys/soc_system fabric, clocked by the slave's avalon_clock, so a test can run without HPS software involvement.
- Captured results are exposed through a small indexed read port, with done/error status, for a later reporting block.

Parameters:
- EXPECTED_ID, 1, value the slave must return at address 0xC; any other value sets id_error.
- POLL_LIMIT, 65535, maximum number of go-polls before aborting with timeout.
- SETTLE_CYCLES, 16, idle cycles after go clears, before counter readback, to let the PLL-domain counters settle.
- DO_PLL_RESET, 0, when 1, pulse pll_reset and wait for locked before the measurement.

Ports:
- avalon_clock, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, level; sampled only in IDLE.
- count_num, in, 32, reference-cycle count; latched on accepted start.
- address, out, 4, Avalon-MM address to slave.
- write, out, 1, Avalon write strobe.
- read, out, 1, Avalon read strobe.
- writedata, out, 32, Avalon write data.
- readdata, in, 32, slave read data; fixed read latency 1.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse at end of sequence.
- timeout_error, out, 1, sticky until next start.
- id_error, out, 1, sticky until next start.
- result_sel, in, 4, result index 0..8.
- result_data, out, 32, combinational mux of captured results; 0 for index >8.

Behaviour:
- Reset: write, read = 0; address, writedata = 0; busy, done, both errors = 0; all result registers = 0; FSM in IDLE.
- Bus rules:
  - No waitrequest; every strobe is exactly 1 cycle.
  - write and read are never high together.
  - Strobes are always separated by at least 1 idle cycle.
- Read timing: read issued in cycle N; readdata sampled at the end of cycle N+1 (state RD_WAIT).
- FSM states and transitions:
  - IDLE: on start, latch count_num, clear both errors, set busy. Go to PR_ASSERT if DO_PLL_RESET, else to WR_CLEAR.
  - PR_ASSERT: write addr 0xB, data 1.
  - PR_DEASSERT: write addr 0xB, data 0.
  - LOCK_POLL: read addr 0xA; on readdata[0] = 1 go to WR_CLEAR; counts against POLL_LIMIT.
  - WR_CLEAR: write addr 0x2, data 0. The slave sets clear and resets ref_count to 1.
  - WR_COUNT: write addr 0x1, data = latched count_num.
  - WR_GO: write addr 0x0, data 1. The slave deasserts clear.
  - GO_POLL: read addr 0x0, then RD_WAIT.
    - readdata[0] = 1: increment poll counter and re-poll.
    - readdata[0] = 0: go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES cycles.
  - READBACK: sequential reads of addresses 3,4,5,6,7,8,9,0xA,0xC into result[0..8] (0xB skipped).
  - FINISH: drop busy, pulse done for 1 cycle, return to IDLE.
- Timeout: when the poll counter reaches POLL_LIMIT in LOCK_POLL or GO_POLL:
  - set timeout_error;
  - write addr 0x0, data 0 to stop the slave;
  - go to FINISH; results are not updated.
- ID check: id_error is set if result[8] != EXPECTED_ID; the sequence still completes.
- count_num = 0: the sequence proceeds normally. The slave ends go after one cycle; results are whatever the slave reports.
- start while busy: ignored. start held high through FINISH: a new run begins on the cycle after FINISH.
- Reset mid-sequence: immediate return to the reset state. Any pending strobe drops asynchronously. The slave is not sent a stop write.
- Poll counter: 32-bit; cleared on each state entry into LOCK_POLL and GO_POLL.

Decomposition:
- Shared package pll_test_pkg holds:
  - slave register address constants: ADDR_GO = 0, ADDR_COUNT = 1, ADDR_CLEAR = 2, ADDR_REF = 3 … ADDR_LOCKED = 0xA, ADDR_PLLRST = 0xB, ADDR_ID = 0xC;
  - result index constants;
  - the FSM state enum.
- One natural sub-module, avalon_master_port: issues single-cycle read/write strobes and returns the read data one cycle later with a rd_valid flag. The sequencer FSM drives it.

Test Plan:
- Slave model with go clearing after 10 cycles; start with count_num = 10 → write sequence (2, 0), (1, 10), (0, 1) observed. Polls continue until go = 0, then 9 reads in order 3–A, C; done pulses once; result_sel 0 returns the model's ref_count value 10.
- Model returns ID 5, EXPECTED_ID = 1 → id_error = 1, done still pulses, result_data at index 8 = 5.
- Model holds go = 1 forever, POLL_LIMIT = 8 → 8 polls, then write (0, 0), timeout_error = 1, done pulses, results remain 0.
- DO_PLL_RESET = 1, locked rises after 3 polls → writes (B, 1) then (B, 0), exactly 3 lock reads, then the normal sequence.
- Assert reset during READBACK → read drops same cycle, busy = 0, all results 0. A new start then completes a full run.
- start pulsed while busy → no extra bus traffic, exactly one done pulse.
